// File: rtl/puf_pkg.sv
// ---------------------------------------------------------------------------
// puf_pkg
//   Shared definitions for the PUF readout sequencer: default parameter
//   values, width helpers, derived localparams and the FSM state encoding.
// ---------------------------------------------------------------------------
package puf_pkg;

  localparam int DEF_ADDR_BITS  = 4;
  localparam int DEF_OUT_BITS   = 8;
  localparam int DEF_NUM_EVALS  = 5;
  localparam int DEF_EXCITE_CYC = 4;
  localparam int DEF_SETTLE_CYC = 3;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of the phase counter, which counts 0..max(excite,settle)-1.
  function automatic int phase_width(input int excite, input int settle);
    int longest;
    longest = (excite > settle) ? excite : settle;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

  localparam int NUM_WORDS = 2 ** DEF_ADDR_BITS;
  localparam int CNT_W     = cnt_width(DEF_NUM_EVALS);
  localparam int PHASE_W   = phase_width(DEF_EXCITE_CYC, DEF_SETTLE_CYC);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_EXCITE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_EMIT   = 3'd5,
    ST_FIN    = 3'd6
  } state_e;

endpackage

// File: rtl/puf_bit_vote.sv
// ---------------------------------------------------------------------------
// puf_bit_vote
//   Majority voter for a single PUF output bit. Counts how many evaluations
//   returned 1 and reports the majority value and whether the bit was
//   inconsistent across evaluations.
// Ports
//   clk, rst_n   clock, async active-low reset
//   i_clr        clear the ones counter (new word)
//   i_inc        sample strobe: add i_bit to the counter
//   i_bit        PUF output bit for the current evaluation
//   o_majority   1 when more than half of the evaluations returned 1
//   o_unstable   1 when the evaluations did not all agree
// ---------------------------------------------------------------------------
module puf_bit_vote #(
  parameter int NUM_EVALS = 5,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_bit,
  output logic o_majority,
  output logic o_unstable
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(i_bit);
    end
  end

  assign o_majority = (r_cnt > CNT_W'(NUM_EVALS / 2));
  assign o_unstable = (r_cnt != '0) && (r_cnt != CNT_W'(NUM_EVALS));

endmodule

// File: rtl/puf_readout_ctrl.sv
// ---------------------------------------------------------------------------
// puf_readout_ctrl
//   Sweeps every address of the PUF array, evaluates each word NUM_EVALS
//   times (clear -> excite -> settle -> sample) and streams out one
//   bitwise-majority word per address with an "unstable" flag.
// Ports
//   clk, rst_n     clock, async active-low reset
//   req            1-cycle pulse starting a full sweep (ignored while busy)
//   busy           sweep in progress
//   done           1-cycle pulse after the last word has been accepted
//   puf_start      PUF START (excitation)
//   puf_reset      PUF reset, active high
//   puf_addr       PUF word address, constant for all evaluations of a word
//   puf_data       registered PUF output word
//   out_valid      voted word available
//   out_ready      consumer accepts when out_valid && out_ready
//   out_addr       address of the voted word
//   out_data       bitwise majority over NUM_EVALS samples
//   out_unstable   any bit disagreed across evaluations
// ---------------------------------------------------------------------------
module puf_readout_ctrl
  import puf_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int OUT_BITS   = DEF_OUT_BITS,
  parameter int NUM_EVALS  = DEF_NUM_EVALS,
  parameter int EXCITE_CYC = DEF_EXCITE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  output logic                 busy,
  output logic                 done,
  output logic                 puf_start,
  output logic                 puf_reset,
  output logic [ADDR_BITS-1:0] puf_addr,
  input  logic [OUT_BITS-1:0]  puf_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [OUT_BITS-1:0]  out_data,
  output logic                 out_unstable
);

  localparam int L_CNT_W   = cnt_width(NUM_EVALS);
  localparam int L_EVAL_W  = cnt_width(NUM_EVALS);
  localparam int L_PHASE_W = phase_width(EXCITE_CYC, SETTLE_CYC);

  localparam logic [ADDR_BITS-1:0] L_LAST_ADDR = {ADDR_BITS{1'b1}};
  localparam logic [L_EVAL_W-1:0]  L_LAST_EVAL = L_EVAL_W'(NUM_EVALS - 1);
  localparam logic [L_PHASE_W-1:0] L_LAST_EXC  = L_PHASE_W'(EXCITE_CYC - 1);
  localparam logic [L_PHASE_W-1:0] L_LAST_SET  = L_PHASE_W'(SETTLE_CYC - 1);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [L_PHASE_W-1:0]   r_phase;
  logic [L_EVAL_W-1:0]    r_eval;
  logic [ADDR_BITS-1:0]   r_addr;

  logic                   w_hs;
  logic                   w_clr;
  logic                   w_inc;
  logic                   w_phase_done;
  logic                   w_eval_last;
  logic                   w_addr_last;
  logic [OUT_BITS-1:0]    w_majority;
  logic [OUT_BITS-1:0]    w_unstable_bits;

  assign w_hs        = (r_state == ST_EMIT) && out_ready;
  assign w_eval_last = (r_eval == L_LAST_EVAL);
  assign w_addr_last = (r_addr == L_LAST_ADDR);
  // Vote counters restart at sweep acceptance and after each accepted word.
  assign w_clr       = ((r_state == ST_IDLE) && req) || w_hs;
  assign w_inc       = (r_state == ST_SAMPLE);

  // Phase counter reaches its terminal count for the timed state we are in.
  assign w_phase_done = ((r_state == ST_EXCITE) && (r_phase == L_LAST_EXC)) ||
                        ((r_state == ST_SETTLE) && (r_phase == L_LAST_SET));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (req) w_next_state = ST_CLEAR;
      ST_CLEAR:  w_next_state = ST_EXCITE;
      ST_EXCITE: if (w_phase_done) w_next_state = ST_SETTLE;
      ST_SETTLE: if (w_phase_done) w_next_state = ST_SAMPLE;
      ST_SAMPLE: w_next_state = w_eval_last ? ST_EMIT : ST_CLEAR;
      ST_EMIT:   if (out_ready) w_next_state = w_addr_last ? ST_FIN : ST_CLEAR;
      ST_FIN:    w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The PUF is held in reset everywhere except while it is excited and its
  // registered output is waiting to be sampled.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    puf_start = 1'b0;
    puf_reset = 1'b1;
    out_valid = 1'b0;
    case (r_state)
      ST_CLEAR:  busy = 1'b1;
      ST_EXCITE: begin
        busy      = 1'b1;
        puf_reset = 1'b0;
        puf_start = 1'b1;
      end
      ST_SETTLE: begin
        busy      = 1'b1;
        puf_reset = 1'b0;
      end
      ST_SAMPLE: begin
        busy      = 1'b1;
        puf_reset = 1'b0;
      end
      ST_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      ST_FIN:    done = 1'b1;
      default:   ;
    endcase
  end

  // ---------------- Phase / eval / address counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (((r_state == ST_EXCITE) || (r_state == ST_SETTLE)) && !w_phase_done) begin
      r_phase <= r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval <= '0;
    end else if ((r_state == ST_IDLE) || w_hs) begin
      r_eval <= '0;
    end else if ((r_state == ST_SAMPLE) && !w_eval_last) begin
      r_eval <= r_eval + 1'b1;
    end
  end

  // Address only moves on an accepted word, so it stays fixed across all
  // evaluations and during backpressure; it never wraps within a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if ((r_state == ST_IDLE) && req) begin
      r_addr <= '0;
    end else if (w_hs && !w_addr_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // ---------------- Per-bit majority voters ----------------
  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_vote
    puf_bit_vote #(
      .NUM_EVALS (NUM_EVALS),
      .CNT_W     (L_CNT_W)
    ) u_vote (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_clr),
      .i_inc      (w_inc),
      .i_bit      (puf_data[gi]),
      .o_majority (w_majority[gi]),
      .o_unstable (w_unstable_bits[gi])
    );
  end

  // Vote counters are frozen in EMIT, so the gated outputs stay stable until
  // the handshake; outside EMIT they read as zero.
  assign puf_addr     = r_addr;
  assign out_addr     = (r_state == ST_EMIT) ? r_addr : '0;
  assign out_data     = (r_state == ST_EMIT) ? w_majority : '0;
  assign out_unstable = (r_state == ST_EMIT) && (|w_unstable_bits);

endmodule
